// File: rtl/warp_fetch_sched_pkg.sv
// Shared GPU definitions: warp count, warp-ID width and the per-warp
// lifecycle encoding used by the fetch scheduler, SIMT_warp and the task
// manager.
package warp_fetch_sched_pkg;

  localparam int NUM_WARPS = 8;
  localparam int WARP_ID_W = 3;

  typedef logic [WARP_ID_W-1:0] warp_id_t;
  typedef logic [NUM_WARPS-1:0] warp_vec_t;

  // Lifecycle of one warp slot
  typedef enum logic [1:0] {
    WARP_IDLE = 2'b00,
    WARP_RUN  = 2'b01,
    WARP_DONE = 2'b10
  } warp_state_e;

  // Pointer value that makes warp 0 the first candidate of the search
  localparam warp_id_t LAST_PTR_RESET = 3'd7;

  // Decode a warp ID into its one-hot lane mask
  function automatic warp_vec_t id_to_onehot(input warp_id_t id);
    warp_vec_t base;
    base = {{(NUM_WARPS-1){1'b0}}, 1'b1};
    return base << id;
  endfunction

endpackage

// File: rtl/warp_fetch_sched_arb.sv
// Rotating-priority selector over eight requesters. The search starts at
// pointer+1 and wraps, so the requester named by the pointer has lowest
// priority. Purely combinational.
module rr_arbiter8
  import warp_fetch_sched_pkg::*;
(
  input  logic [7:0] request,
  input  logic [2:0] pointer,
  output logic [7:0] grant_oh,
  output logic [2:0] grant_id
);

  logic       found_s;
  logic       hit_s;
  logic [2:0] cand_s;

  // Walk the eight positions in priority order, keep the first requester
  always_comb begin
    found_s  = 1'b0;
    hit_s    = 1'b0;
    cand_s   = 3'd0;
    grant_id = 3'd0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      cand_s   = pointer + 3'd1 + 3'(i);
      hit_s    = request[cand_s] & ~found_s;
      grant_id = hit_s ? cand_s : grant_id;
      found_s  = found_s | hit_s;
    end
    grant_oh = found_s ? id_to_onehot(grant_id) : 8'h00;
  end

endmodule

// File: rtl/warp_fetch_sched.sv
// Warp fetch scheduler: tracks the IDLE/RUN/DONE lifecycle of eight warps,
// picks one eligible warp per cycle for instruction fetch with rotating
// priority, and tells the task manager which warps are live and when all
// launched work has finished.
module warp_fetch_sched
  import warp_fetch_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       Start_TM_WS,
  input  logic [2:0] WarpID_TM_WS,
  input  logic       Exit_ID_WS,
  input  logic [2:0] WarpID_ID_WS,
  input  logic [7:0] Stall_SIMT_WS,
  input  logic [7:0] IBFull_IB_WS,
  input  logic       Freeze_IF_WS,
  output logic       Grant_WS_IF,
  output logic [2:0] WarpID_WS_IF,
  output logic [7:0] GrantOH_WS_IF,
  output logic [7:0] Active_WS_TM,
  output logic       AllDone_WS_TM
);

  warp_state_e state_r     [NUM_WARPS];
  warp_state_e state_nxt_s [NUM_WARPS];

  logic [2:0] last_ptr_r;
  logic       all_done_r;

  logic [7:0] run_s;
  logic [7:0] run_nxt_s;
  logic [7:0] done_nxt_s;
  logic [7:0] eligible_s;
  logic [7:0] request_s;
  logic [7:0] arb_oh_s;
  logic [2:0] arb_id_s;
  logic       grant_s;

  // Per-warp lifecycle: an Exit on a RUN warp wins over a Start on the same
  // warp; a Start only takes effect on a warp that is not already RUN
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      state_nxt_s[w] = state_r[w];
      if (Exit_ID_WS && (WarpID_ID_WS == 3'(w)) && (state_r[w] == WARP_RUN)) begin
        state_nxt_s[w] = WARP_DONE;
      end else if (Start_TM_WS && (WarpID_TM_WS == 3'(w)) && (state_r[w] != WARP_RUN)) begin
        state_nxt_s[w] = WARP_RUN;
      end else begin
        state_nxt_s[w] = state_r[w];
      end
    end
  end

  // Flatten current and next lifecycle into lane masks
  always_comb begin
    run_s      = 8'h00;
    run_nxt_s  = 8'h00;
    done_nxt_s = 8'h00;
    for (int w = 0; w < NUM_WARPS; w++) begin
      run_s[w]      = (state_r[w] == WARP_RUN);
      run_nxt_s[w]  = (state_nxt_s[w] == WARP_RUN);
      done_nxt_s[w] = (state_nxt_s[w] == WARP_DONE);
    end
  end

  // A warp may fetch when running, not stalled by SIMT and its buffer has room;
  // a frozen fetch stage withdraws every request so no grant is issued
  always_comb begin
    eligible_s = run_s & ~Stall_SIMT_WS & ~IBFull_IB_WS;
    request_s  = Freeze_IF_WS ? 8'h00 : eligible_s;
  end

  rr_arbiter8 u_arb (
    .request  (request_s),
    .pointer  (last_ptr_r),
    .grant_oh (arb_oh_s),
    .grant_id (arb_id_s)
  );

  assign grant_s = |request_s;

  // Lifecycle registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_r[w] <= WARP_IDLE;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_r[w] <= state_nxt_s[w];
      end
    end
  end

  // Remember the last granted warp so it drops to lowest priority next time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ptr_r <= LAST_PTR_RESET;
    end else if (grant_s) begin
      last_ptr_r <= arb_id_s;
    end else begin
      last_ptr_r <= last_ptr_r;
    end
  end

  // Completion flag: computed from the lifecycle being written this edge, so it
  // rises the cycle after the final exit and falls the cycle after a launch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      all_done_r <= 1'b0;
    end else begin
      all_done_r <= ~(|run_nxt_s) & (|done_nxt_s);
    end
  end

  assign Grant_WS_IF   = grant_s;
  assign WarpID_WS_IF  = grant_s ? arb_id_s : 3'd0;
  assign GrantOH_WS_IF = grant_s ? arb_oh_s : 8'h00;
  assign Active_WS_TM  = run_s;
  assign AllDone_WS_TM = all_done_r;

endmodule

// File: tb/tb_warp_fetch_sched.sv
// Self-checking bench for warp_fetch_sched. Each scenario task drives one
// cycle of stimulus at a time, pushes the grant it expects into a scoreboard
// queue and pops/compares it once the combinational grant has settled.
module tb_warp_fetch_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] start_id;
  logic       exit_v;
  logic [2:0] exit_id;
  logic [7:0] stall;
  logic [7:0] ibfull;
  logic       freeze;
  logic       grant;
  logic [2:0] grant_id;
  logic [7:0] grant_oh;
  logic [7:0] active;
  logic       all_done;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  warp_fetch_sched dut (
    .clk           (clk),
    .rst           (rst),
    .Start_TM_WS   (start),
    .WarpID_TM_WS  (start_id),
    .Exit_ID_WS    (exit_v),
    .WarpID_ID_WS  (exit_id),
    .Stall_SIMT_WS (stall),
    .IBFull_IB_WS  (ibfull),
    .Freeze_IF_WS  (freeze),
    .Grant_WS_IF   (grant),
    .WarpID_WS_IF  (grant_id),
    .GrantOH_WS_IF (grant_oh),
    .Active_WS_TM  (active),
    .AllDone_WS_TM (all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive at the falling edge, expect warp e (-1 = no grant),
  // then pop the scoreboard and compare before the next rising edge.
  task automatic step(input logic st, input logic [2:0] sid, input logic ex,
                      input logic [2:0] eid, input logic [7:0] stl,
                      input logic [7:0] ibf, input logic frz, input int e);
    int         got_e;
    logic       eg;
    logic [2:0] eid_x;
    logic [7:0] eoh;
    @(negedge clk);
    start = st; start_id = sid; exit_v = ex; exit_id = eid;
    stall = stl; ibfull = ibf; freeze = frz;
    exp_q.push_back(e);
    #2;
    got_e = exp_q.pop_front();
    eg    = (got_e >= 0);
    eid_x = eg ? 3'(got_e) : 3'd0;
    eoh   = eg ? (8'h01 << got_e) : 8'h00;
    total++;
    if (grant !== eg) begin
      bad++;
      $display("FAIL grant_valid t=%0t got=%b want=%b", $time, grant, eg);
    end
    total++;
    if (grant_id !== eid_x) begin
      bad++;
      $display("FAIL grant_id t=%0t got=%0d want=%0d", $time, grant_id, eid_x);
    end
    total++;
    if (grant_oh !== eoh) begin
      bad++;
      $display("FAIL grant_onehot t=%0t got=%b want=%b", $time, grant_oh, eoh);
    end
    #1;
  endtask

  task automatic idle(input int e);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, e);
  endtask

  task automatic launch_frozen(input logic [2:0] w);
    step(1'b1, w, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, -1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0; start_id = 3'd0; exit_v = 1'b0; exit_id = 3'd0;
    stall = 8'h00; ibfull = 8'h00; freeze = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0; start_id = 3'd0; exit_v = 1'b0; exit_id = 3'd0;
    stall = 8'h00; ibfull = 8'h00; freeze = 1'b0;
    #1;
    total++;
    if ({grant, grant_id, grant_oh} !== 12'h000) begin
      bad++;
      $display("FAIL reset_grant got=%b/%0d/%b want=0/0/0", grant, grant_id, grant_oh);
    end
    total++;
    if (active !== 8'h00) begin
      bad++;
      $display("FAIL reset_active got=%b want=00000000", active);
    end
    total++;
    if (all_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_alldone got=%b want=0", all_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    apply_reset();
    step(1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, -1);
    step(1'b1, 3'd1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 0);
    step(1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1);
    idle(2); idle(0); idle(1); idle(2); idle(0); idle(1);
    total++;
    if (active !== 8'b0000_0111) begin
      bad++;
      $display("FAIL rr_active got=%b want=00000111", active);
    end
    total++;
    if (all_done !== 1'b0) begin
      bad++;
      $display("FAIL rr_alldone got=%b want=0", all_done);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    launch_frozen(3'd0); launch_frozen(3'd1); launch_frozen(3'd2); launch_frozen(3'd3);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'b0000_0010, 8'h00, 1'b0, 0);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'b0000_0010, 8'h00, 1'b0, 2);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'b0000_0010, 8'h00, 1'b0, 3);
    idle(0); idle(1); idle(2);
  endtask

  task automatic test_freeze();
    apply_reset();
    launch_frozen(3'd0); launch_frozen(3'd1); launch_frozen(3'd2); launch_frozen(3'd3);
    idle(0); idle(1); idle(2);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, -1);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, -1);
    idle(3); idle(0);
  endtask

  task automatic test_ibfull();
    apply_reset();
    step(1'b1, 3'd5, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, -1);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'b0000_0000, 1'b0, 5);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'b0010_0000, 1'b0, -1);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'b0000_0000, 1'b0, 5);
    idle(5);
    total++;
    if (active !== 8'b0010_0000) begin
      bad++;
      $display("FAIL ibf_active got=%b want=00100000", active);
    end
  endtask

  task automatic test_exit_alldone();
    apply_reset();
    launch_frozen(3'd3); launch_frozen(3'd4); launch_frozen(3'd7);
    idle(3);
    step(1'b0, 3'd0, 1'b1, 3'd4, 8'h00, 8'h00, 1'b0, 4);
    step(1'b0, 3'd0, 1'b1, 3'd3, 8'h00, 8'h00, 1'b0, 7);
    step(1'b0, 3'd0, 1'b1, 3'd7, 8'h00, 8'h00, 1'b0, 7);
    total++;
    if (all_done !== 1'b0) begin
      bad++;
      $display("FAIL alldone_before_last_exit got=%b want=0", all_done);
    end
    idle(-1);
    total++;
    if (all_done !== 1'b1) begin
      bad++;
      $display("FAIL alldone_after_last_exit got=%b want=1", all_done);
    end
    total++;
    if (active !== 8'h00) begin
      bad++;
      $display("FAIL exit_active got=%b want=00000000", active);
    end
    step(1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, -1);
    total++;
    if (all_done !== 1'b1) begin
      bad++;
      $display("FAIL alldone_in_start_cycle got=%b want=1", all_done);
    end
    idle(0);
    total++;
    if (all_done !== 1'b0) begin
      bad++;
      $display("FAIL alldone_after_start got=%b want=0", all_done);
    end
  endtask

  task automatic test_start_exit_and_midreset();
    apply_reset();
    step(1'b1, 3'd6, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, -1);
    step(1'b1, 3'd6, 1'b1, 3'd6, 8'h00, 8'h00, 1'b0, 6);
    idle(-1);
    total++;
    if (active !== 8'h00) begin
      bad++;
      $display("FAIL start_exit_active got=%b want=00000000", active);
    end
    total++;
    if (all_done !== 1'b1) begin
      bad++;
      $display("FAIL start_exit_alldone got=%b want=1", all_done);
    end
    launch_frozen(3'd1); launch_frozen(3'd2);
    idle(1); idle(2); idle(1);
    rst = 1'b0;
    #1;
    total++;
    if ({grant, grant_id, grant_oh} !== 12'h000) begin
      bad++;
      $display("FAIL midreset_grant got=%b/%0d/%b want=0/0/0", grant, grant_id, grant_oh);
    end
    total++;
    if ({active, all_done} !== 9'h000) begin
      bad++;
      $display("FAIL midreset_status got=%b/%b want=00000000/0", active, all_done);
    end
    start = 1'b0; exit_v = 1'b0; freeze = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    launch_frozen(3'd0); launch_frozen(3'd5);
    idle(0); idle(5); idle(0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_freeze();
    test_ibfull();
    test_exit_alldone();
    test_start_exit_and_midreset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/warp_fetch_sched.md
WARP_FETCH_SCHED -- requirements
Module: warp_fetch_sched

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Start_TM_WS  in  1  task manager launches a warp.
REQ-004 SHALL have ports: WarpID_TM_WS  in  3  warp launched by Start_TM_WS.
REQ-005 SHALL have ports: Exit_ID_WS  in  1  decode saw EXIT for a warp.
REQ-006 SHALL have ports: WarpID_ID_WS  in  3  warp retired by Exit_ID_WS.
REQ-007 SHALL have ports: Stall_SIMT_WS  in  8  per-warp Stall_SIMT_IF from the SIMT_warp instances, bit w = warp w.
REQ-008 SHALL have ports: IBFull_IB_WS  in  8  per-warp instruction buffer full.
REQ-009 SHALL have ports: Freeze_IF_WS  in  1  fetch cannot accept a grant (I-cache miss).
REQ-010 SHALL have ports: Grant_WS_IF  out  1  a fetch grant is issued this cycle.
REQ-011 SHALL have ports: WarpID_WS_IF  out  3  granted warp, 0 when no grant.
REQ-012 SHALL have ports: GrantOH_WS_IF  out  8  one-hot grant, all zero when no grant.
REQ-013 SHALL have ports: Active_WS_TM  out  8  bit w high while warp w is RUN.
REQ-014 SHALL have ports: AllDone_WS_TM  out  1  registered; no warp RUN and at least one warp DONE.

Function
REQ-015 SHALL keep one 2-bit state per warp: IDLE, RUN, DONE.
REQ-016 SHALL move warp WarpID_TM_WS from IDLE or DONE to RUN on the edge where Start_TM_WS=1; Start on a RUN warp SHALL be ignored.
REQ-017 SHALL move warp WarpID_ID_WS from RUN to DONE on the edge where Exit_ID_WS=1; Exit on a non-RUN warp SHALL be ignored.
REQ-018 SHALL, when Start and Exit target the same warp in one cycle, apply Exit if it is RUN, else apply Start.
REQ-019 SHALL define eligible(w) = RUN(w) & ~Stall_SIMT_WS[w] & ~IBFull_IB_WS[w], all from current-cycle values.
REQ-020 SHALL grant combinationally (zero latency) the first eligible warp searching from (last_ptr+1) mod 8 upward with wrap-around.
REQ-021 SHALL drive Grant_WS_IF=0 when Freeze_IF_WS=1 or no warp is eligible.
REQ-022 SHALL load the granted ID into the 3-bit last_ptr on the edge of a grant; with no grant last_ptr SHALL hold.
REQ-023 SHALL keep a granted warp that exits in the same cycle granted for that cycle; it becomes ineligible from the next cycle.
REQ-024 SHALL grant warp w in consecutive cycles only when w is the sole eligible warp.
REQ-025 SHALL keep GrantOH_WS_IF, WarpID_WS_IF and Grant_WS_IF mutually consistent every cycle.
REQ-026 SHALL make AllDone_WS_TM go high one cycle after the last RUN warp enters DONE.
REQ-027 SHALL make AllDone_WS_TM drop one cycle after any Start.

Reset
REQ-028 SHALL, on rst=0, asynchronously set all warps IDLE, last_ptr=7, AllDone_WS_TM=0.
REQ-029 SHALL make Grant_WS_IF=0 and Active_WS_TM=0 follow from the reset state.
REQ-030 SHALL discard a grant in progress when reset asserts mid-operation, with no partial state update.
REQ-031 SHALL make warp 0 first in priority after reset release.

Structure
REQ-032 SHALL take NUM_WARPS=8, the warp-ID width 3 and the IDLE/RUN/DONE state encoding from the shared GPU package, also used by SIMT_warp and the task manager.
REQ-033 SHALL implement the rotating priority search as one sub-module rr_arbiter8: request[8] and pointer[3] in, grant one-hot and ID out, purely combinational.

Verification
REQ-034 SHALL cover: reset, Start warps 0,1,2, no stalls -> grants 0,1,2,0,1,2 on consecutive cycles, Active=00000111.
REQ-035 SHALL cover: warps 0-3 RUN, Stall_SIMT_WS=00000010 for 3 cycles -> grant order 0,2,3,0; warp 1 resumes after stall drops.
REQ-036 SHALL cover: Freeze_IF_WS=1 for 2 cycles after granting warp 2 -> Grant=0, last_ptr held, warp 3 granted next.
REQ-037 SHALL cover: only warp 5 RUN with IBFull toggling 0,1,0 -> grants 5,none,5.
REQ-038 SHALL cover: Exit warp 4 while granted, other RUN warps exiting in turn -> warp 4 granted that cycle, never again; AllDone=1 one cycle after the last exit.
REQ-039 SHALL cover: Start and Exit on warp 6 in the same cycle while RUN -> DONE; rst pulsed low mid-stream -> all outputs zero, warp 0 first after restart.
